// File: rtl/decoder_4_16_acc.sv
// decoder_4_16_acc: 4-to-16 one-hot decoder with a frame accumulator.
// Each accepted code is decoded to a registered one-hot value and folded
// into a per-frame mask, saturating count and duplicate flag. The frame is
// presented on a valid/ready output handshake once its last code arrives.
module decoder_4_16_acc #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [3:0]       in_code,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0]      out_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_mask,
    output logic [CNT_W-1:0] out_count,
    output logic             out_dup
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] COUNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [15:0]      frame_mask;
    logic [CNT_W-1:0] frame_count;
    logic             frame_dup;
    logic [15:0]      decoded;
    logic             accept;
    logic             consume;

    // Ready depends only on registered state and enable; held low in reset.
    assign in_ready  = rst_n && enable && (state != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign consume   = out_valid && out_ready;
    assign decoded   = 16'h0001 << in_code;

    assign out_mask  = frame_mask;
    assign out_count = frame_count;
    assign out_dup   = frame_dup;

    // Next-state decode for the frame FSM.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    next_state = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (consume) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame accumulator: clears on the output handshake, folds in accepted codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_mask  <= '0;
            frame_count <= '0;
            frame_dup   <= 1'b0;
        end else if (consume) begin
            frame_mask  <= '0;
            frame_count <= '0;
            frame_dup   <= 1'b0;
        end else if (accept) begin
            frame_mask <= frame_mask | decoded;
            if (frame_count != COUNT_MAX) begin
                frame_count <= frame_count + COUNT_ONE;
            end
            if (frame_mask[in_code]) begin
                frame_dup <= 1'b1;
            end
        end
    end

    // One-hot of the most recent accepted code; untouched by the frame handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_onehot <= '0;
        end else if (accept) begin
            out_onehot <= decoded;
        end
    end

endmodule

// File: tb/tb_decoder_4_16_acc.sv
// Testbench for decoder_4_16_acc: a frame-level model (list of accepted codes)
// is compared against the DUT on every falling clock edge, and directed
// scenarios pin the model with hand-computed values.
module tb_decoder_4_16_acc;

    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             in_valid;
    logic [3:0]       in_code;
    logic             in_last;
    logic             in_ready;
    logic [15:0]      out_onehot;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_mask;
    logic [CNT_W-1:0] out_count;
    logic             out_dup;

    decoder_4_16_acc #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mask   (out_mask),
        .out_count  (out_count),
        .out_dup    (out_dup)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the codes of the current frame, whether it is presented, last one-hot.
    int          frame_codes[$];
    bit          presented = 1'b0;
    logic [15:0] m_onehot  = 16'h0;

    function automatic logic [15:0] m_mask();
        logic [15:0] m = 16'h0;
        foreach (frame_codes[i]) m[frame_codes[i]] = 1'b1;
        return m;
    endfunction

    function automatic int m_count();
        return (frame_codes.size() > CMAX) ? CMAX : frame_codes.size();
    endfunction

    function automatic bit m_dup();
        for (int i = 0; i < frame_codes.size(); i++)
            for (int j = 0; j < i; j++)
                if (frame_codes[i] == frame_codes[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return rst_n && enable && !presented;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs held across it.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (presented && out_ready) begin
                frame_codes.delete();
                presented = 1'b0;
            end else if (in_valid && enable) begin
                if (!presented) begin
                    frame_codes.push_back(int'(in_code));
                    m_onehot = 16'h0001 << in_code;
                    if (in_last) presented = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic send(input int code, input bit last);
        in_valid = 1'b1;
        in_code  = 4'(code);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume_frame();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        check("in_ready",   32'(in_ready),   32'(m_ready()));
        check("out_valid",  32'(out_valid),  32'(presented));
        check("out_onehot", 32'(out_onehot), 32'(m_onehot));
        check("out_mask",   32'(out_mask),   32'(m_mask()));
        check("out_count",  32'(out_count),  32'(m_count()));
        check("out_dup",    32'(out_dup),    32'(m_dup()));
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_code   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst in_ready",  32'(in_ready),  32'h0);
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst out_mask",  32'(out_mask),  32'h0);
        #11;
        rst_n  = 1'b1;
        enable = 1'b1;

        // Single-code frame, accepted on the first edge after reset.
        send(3, 1'b1);
        check("single onehot", 32'(out_onehot), 32'h0008);
        check("single valid",  32'(out_valid),  32'h1);
        check("single mask",   32'(out_mask),   32'h0008);
        check("single count",  32'(out_count),  32'h1);
        check("single dup",    32'(out_dup),    32'h0);
        consume_frame();

        // Multi-code frame.
        send(0, 1'b0);  check("multi oh0",  32'(out_onehot), 32'h0001);
        send(4, 1'b0);  check("multi oh4",  32'(out_onehot), 32'h0010);
        send(8, 1'b0);  check("multi oh8",  32'(out_onehot), 32'h0100);
        send(15, 1'b1); check("multi oh15", 32'(out_onehot), 32'h8000);
        check("multi mask",  32'(out_mask),  32'h8111);
        check("multi count", 32'(out_count), 32'h4);
        check("multi dup",   32'(out_dup),   32'h0);
        consume_frame();
        check("multi onehot kept", 32'(out_onehot), 32'h8000);

        // Duplicates with backpressure; input offered while held is not taken.
        send(5, 1'b0);
        send(5, 1'b0);
        send(9, 1'b1);
        in_valid = 1'b1; in_code = 4'h7; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold in_ready", 32'(in_ready),  32'h0);
            check("hold mask",     32'(out_mask),  32'h0220);
            check("hold count",    32'(out_count), 32'h3);
            check("hold dup",      32'(out_dup),   32'h1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("released valid", 32'(out_valid), 32'h0);
        check("released mask",  32'(out_mask),  32'h0);
        check("released count", 32'(out_count), 32'h0);
        tick();
        in_valid = 1'b0;
        check("late accept count", 32'(out_count), 32'h1);
        send(7, 1'b1);
        consume_frame();

        // Enable gating mid-frame.
        send(1, 1'b0);
        enable = 1'b0;
        in_valid = 1'b1; in_code = 4'h2; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gated in_ready", 32'(in_ready),  32'h0);
            check("gated mask",     32'(out_mask),  32'h0002);
            check("gated count",    32'(out_count), 32'h1);
        end
        enable = 1'b1;
        send(2, 1'b1);
        check("resumed mask",  32'(out_mask),  32'h0006);
        check("resumed count", 32'(out_count), 32'h2);
        consume_frame();

        // Saturation: 40 codes then last.
        for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 15)), 1'b0);
        send(6, 1'b1);
        check("sat count", 32'(out_count), 32'd31);
        consume_frame();

        // Asynchronous reset between edges during ACCUM.
        send(1, 1'b0);
        send(2, 1'b0);
        #2;
        rst_n = 1'b0;
        frame_codes.delete();
        presented = 1'b0;
        m_onehot  = 16'h0;
        #1;
        check("arst onehot",   32'(out_onehot), 32'h0);
        check("arst mask",     32'(out_mask),   32'h0);
        check("arst count",    32'(out_count),  32'h0);
        check("arst in_ready", 32'(in_ready),   32'h0);
        #3;
        rst_n = 1'b1;
        send(10, 1'b1);
        check("post-rst mask",  32'(out_mask),  32'h0400);
        check("post-rst count", 32'(out_count), 32'h1);
        consume_frame();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1);
            in_code   = 4'($urandom_range(0, 15));
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
